// File: rtl/rx_if.sv
// Serial receive port bundle: line and tick in, received byte and status out.
// The receiver takes the slave side; the consumer/driver takes the master side.
interface rx_if;
  logic       rx;
  logic       rx_clk;
  logic       rd_en;
  logic [7:0] data_out;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  modport slave (
    input  rx, rx_clk, rd_en,
    output data_out, rdy, frame_err, overrun, rx_busy
  );

  modport master (
    output rx, rx_clk, rd_en,
    input  data_out, rdy, frame_err, overrun, rx_busy
  );
endinterface

// File: rtl/rx.sv
// 8N1 UART receiver timed by an external oversampling tick; samples each bit
// at mid-period and reports ready, framing error and overrun to the consumer.
module rx #(
  parameter int OVERSAMPLE = 16
) (
  input logic clk,
  input logic rst_n,
  rx_if.slave bus
);
  localparam int            CW      = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_sync;
  logic          w_rx_s;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bitpos, w_bitpos_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          w_good_stop, w_bad_stop;
  logic [7:0]    r_data;
  logic          r_rdy, r_frame_err, r_overrun;

  // Preset to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], bus.rx};
  end
  assign w_rx_s = r_sync[1];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bitpos <= '0;
      r_shift  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bitpos <= w_bitpos_nxt;
      r_shift  <= w_shift_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bitpos_nxt = r_bitpos;
    w_shift_nxt  = r_shift;
    w_good_stop  = 1'b0;
    w_bad_stop   = 1'b0;
    if (bus.rx_clk) begin
      case (r_state)
        IDLE: if (!w_rx_s) begin
          w_state_nxt = START;
          w_cnt_nxt   = '0;
        end
        START: begin
          // Re-check the line half a bit in; a high level means a glitch.
          if (r_cnt == HALF_M1) begin
            if (!w_rx_s) begin
              w_state_nxt  = DATA;
              w_cnt_nxt    = '0;
              w_bitpos_nxt = '0;
            end else begin
              w_state_nxt  = IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == FULL_M1) begin
            w_shift_nxt[r_bitpos] = w_rx_s;
            w_cnt_nxt             = '0;
            if (r_bitpos == 3'd7) w_state_nxt  = STOP;
            else                  w_bitpos_nxt = r_bitpos + 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == FULL_M1) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_good_stop = w_rx_s;
            w_bad_stop  = !w_rx_s;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // A new byte wins over a same-cycle acknowledge; a bad stop keeps old data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data      <= '0;
      r_rdy       <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_good_stop) begin
      r_data      <= r_shift;
      r_rdy       <= 1'b1;
      r_frame_err <= 1'b0;
      r_overrun   <= !bus.rd_en && (r_overrun || r_rdy);
    end else begin
      if (bus.rd_en) begin
        r_rdy       <= 1'b0;
        r_frame_err <= 1'b0;
        r_overrun   <= 1'b0;
      end
      if (w_bad_stop) r_frame_err <= 1'b1;
    end
  end

  assign bus.data_out  = r_data;
  assign bus.rdy       = r_rdy;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;
  assign bus.rx_busy   = (r_state != IDLE);
endmodule

// File: tb/tb_rx.sv
// Bench for the UART receiver: a frame-level reference (sample points at fixed
// tick offsets from the detected start edge) checked every cycle, plus literal checks.
module tb_rx;
  logic clk = 1'b0;
  logic rst_n;
  rx_if bus ();

  rx #(.OVERSAMPLE(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Oversample tick: one clk wide, every 4 clk, changed on the falling edge.
  initial begin
    int ph = 0;
    bus.rx_clk = 1'b0;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 4;
      bus.rx_clk = (ph == 0);
    end
  end

  // Reference: the line is seen two clocks late; after a start edge is seen on
  // a tick, the start is confirmed at tick 8 and bit k is taken at tick 8+16k.
  logic [1:0] m_hist;
  bit         m_active;
  int         m_t;
  logic [7:0] m_byte, m_data;
  bit         m_rdy, m_fe, m_ovr;

  initial begin
    forever begin
      logic view;
      bit   good, bad;
      int   k;
      @(posedge clk);
      if (!rst_n) begin
        m_hist = 2'b11; m_active = 0; m_t = 0; m_byte = '0;
        m_data = '0; m_rdy = 0; m_fe = 0; m_ovr = 0;
      end else begin
        view = m_hist[1];
        good = 0;
        bad  = 0;
        if (bus.rx_clk) begin
          if (!m_active) begin
            if (!view) begin m_active = 1; m_t = 0; end
          end else begin
            m_t++;
            if (m_t == 8) begin
              if (view) m_active = 0;
            end else if (m_t > 8 && (m_t - 8) % 16 == 0) begin
              k = (m_t - 8) / 16;
              if (k <= 8) m_byte[k-1] = view;
              else begin m_active = 0; good = view; bad = !view; end
            end
          end
        end
        if (good) begin
          m_data = m_byte;
          m_ovr  = bus.rd_en ? 1'b0 : (m_ovr | m_rdy);
          m_rdy  = 1;
          m_fe   = 0;
        end else begin
          if (bus.rd_en) begin m_rdy = 0; m_fe = 0; m_ovr = 0; end
          if (bad) m_fe = 1;
        end
        m_hist = {m_hist[0], bus.rx};
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon) begin
        check("data_out",  bus.data_out,  m_data);
        check("rdy",       bus.rdy,       m_rdy);
        check("frame_err", bus.frame_err, m_fe);
        check("overrun",   bus.overrun,   m_ovr);
        check("rx_busy",   bus.rx_busy,   m_active);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_rd();
    bus.rd_en = 1'b1;
    cycles(1);
    bus.rd_en = 1'b0;
  endtask

  // Drives one frame, 64 clk per bit. rd_at_stop raises rd_en for exactly the
  // stop-sample clock; abort_bit >= 0 pulses reset halfway into that bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_b,
                            input bit rd_at_stop, input int abort_bit);
    logic [9:0] bits;
    bit fired = 0;
    bits = {stop_b, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx = bits[i];
      for (int j = 0; j < 64; j++) begin
        if (i == abort_bit && j == 32) begin
          rst_n = 1'b0;
          cycles(1);
          rst_n  = 1'b1;
          bus.rx = 1'b1;
          return;
        end
        bus.rd_en = rd_at_stop && m_active && (m_t == 151) && bus.rx_clk;
        if (bus.rd_en) fired = 1;
        cycles(1);
      end
    end
    bus.rd_en = 1'b0;
    bus.rx    = 1'b1;
    if (rd_at_stop) check("rd_at_stop_hit", fired, 1'b1);
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.rx     = 1'b1;
    bus.rd_en  = 1'b0;
    cycles(4);
    mon   = 1'b1;
    rst_n = 1'b1;
    check("reset_data",  bus.data_out,  8'h00);
    check("reset_rdy",   bus.rdy,       1'b0);
    check("reset_busy",  bus.rx_busy,   1'b0);
    cycles(20);

    // Good 0x55, then acknowledge.
    send_frame(8'h55, 1'b1, 0, -1);
    cycles(20);
    check("t1_data", bus.data_out,  8'h55);
    check("t1_rdy",  bus.rdy,       1'b1);
    check("t1_fe",   bus.frame_err, 1'b0);
    check("t1_ovr",  bus.overrun,   1'b0);
    pulse_rd();
    check("t1_rd_clears", bus.rdy, 1'b0);

    // Three-tick low glitch aborts from START.
    bus.rx = 1'b0;
    cycles(12);
    bus.rx = 1'b1;
    cycles(48);
    check("t2_busy", bus.rx_busy,   1'b0);
    check("t2_data", bus.data_out,  8'h55);
    check("t2_rdy",  bus.rdy,       1'b0);
    check("t2_fe",   bus.frame_err, 1'b0);

    // Bad stop keeps old data, then a good 0x0F.
    send_frame(8'hA3, 1'b0, 0, -1);
    cycles(100);
    check("t3_fe",   bus.frame_err, 1'b1);
    check("t3_rdy",  bus.rdy,       1'b0);
    check("t3_data", bus.data_out,  8'h55);
    send_frame(8'h0F, 1'b1, 0, -1);
    cycles(20);
    check("t3b_data", bus.data_out,  8'h0F);
    check("t3b_rdy",  bus.rdy,       1'b1);
    check("t3b_fe",   bus.frame_err, 1'b0);
    pulse_rd();

    // Back-to-back without acknowledge overruns.
    send_frame(8'h12, 1'b1, 0, -1);
    send_frame(8'h34, 1'b1, 0, -1);
    cycles(20);
    check("t4_data", bus.data_out, 8'h34);
    check("t4_rdy",  bus.rdy,      1'b1);
    check("t4_ovr",  bus.overrun,  1'b1);
    pulse_rd();
    check("t4_rdy_clr", bus.rdy,     1'b0);
    check("t4_ovr_clr", bus.overrun, 1'b0);

    // Acknowledge coincident with the second byte's stop sample.
    send_frame(8'h66, 1'b1, 0, -1);
    cycles(20);
    send_frame(8'h9C, 1'b1, 1, -1);
    cycles(20);
    check("t5_data", bus.data_out, 8'h9C);
    check("t5_rdy",  bus.rdy,      1'b1);
    check("t5_ovr",  bus.overrun,  1'b0);

    // Reset during data bit 3, then a clean 0xC3.
    send_frame(8'hFF, 1'b1, 0, 4);
    check("t6_data", bus.data_out,  8'h00);
    check("t6_rdy",  bus.rdy,       1'b0);
    check("t6_fe",   bus.frame_err, 1'b0);
    check("t6_ovr",  bus.overrun,   1'b0);
    check("t6_busy", bus.rx_busy,   1'b0);
    cycles(100);
    send_frame(8'hC3, 1'b1, 0, -1);
    cycles(20);
    check("t6b_data", bus.data_out, 8'hC3);
    check("t6b_rdy",  bus.rdy,      1'b1);

    mon = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
